periph_port_arbiter: RTL and testbench

//  Shares one Hermes border local port (one PE port slot on the mesh edge) between N_SRC peripherals.
//  TX: packet-granular round-robin arbitration of peripheral->NoC traffic.
//  RX: steers NoC->peripheral packets to one peripheral using the header flit's peripheral-id field.

---
 rtl/periph_arb_pkg.sv | 7 +
 rtl/periph_pkt_tracker.sv | 57 +++++
 rtl/periph_port_arbiter.sv | 128 ++++++++++++
 tb/tb_periph_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the peripheral port arbiter.
package periph_arb_pkg;
  typedef enum logic [1:0] {PKT_IDLE, PKT_HDR, PKT_SIZE, PKT_PAYLOAD} pkt_state_e;
  localparam int FLIT_W      = 32;
  localparam int PID_LSB_DEF = 16;
  localparam int PID_W_DEF   = 3;
endpackage

// File: rtl/periph_pkt_tracker.sv
// Packet framing tracker: header, size, then size payload flits.
// HAS_IDLE=0 makes the FSM loop HDR->...->HDR with no arbitration state.
module periph_pkt_tracker
  import periph_arb_pkg::*;
#(
  parameter bit HAS_IDLE = 1'b1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              xfer,
  input  logic [FLIT_W-1:0] data,
  output pkt_state_e        state,
  output logic              last_o
);
  localparam pkt_state_e END_ST = HAS_IDLE ? PKT_IDLE : PKT_HDR;

  pkt_state_e        state_nxt;
  logic [FLIT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= END_ST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_o    = 1'b0;
    unique case (state)
      PKT_IDLE: if (start) state_nxt = PKT_HDR;
      PKT_HDR:  if (xfer) state_nxt = PKT_SIZE;
      PKT_SIZE: if (xfer) begin
        cnt_nxt = data;
        if (data == '0) begin
          last_o    = 1'b1;
          state_nxt = END_ST;
        end else begin
          state_nxt = PKT_PAYLOAD;
        end
      end
      PKT_PAYLOAD: if (xfer) begin
        cnt_nxt = cnt - FLIT_W'(1);
        if (cnt == FLIT_W'(1)) begin
          last_o    = 1'b1;
          state_nxt = END_ST;
        end
      end
      default: state_nxt = END_ST;
    endcase
  end
endmodule

// File: rtl/periph_port_arbiter.sv
// Shares one mesh-edge local port among N_SRC peripherals: round-robin TX, pid-steered RX.
// Optional PERIPH_ARB_STATS_EN adds per-source completed-packet counters (pkt_cnt_o).
module periph_port_arbiter
  import periph_arb_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int PID_LSB = PID_LSB_DEF,
  parameter int PID_W   = PID_W_DEF
)(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          release_i,
  input  logic [N_SRC-1:0]              src_tx_i,
  output logic [N_SRC-1:0]              src_credit_o,
  input  logic [N_SRC-1:0][FLIT_W-1:0]  src_data_i,
  output logic                          noc_tx_o,
  input  logic                          noc_credit_i,
  output logic [FLIT_W-1:0]             noc_data_o,
  input  logic                          noc_rx_i,
  output logic                          noc_credit_o,
  input  logic [FLIT_W-1:0]             noc_data_i,
  output logic [N_SRC-1:0]              dst_rx_o,
  input  logic [N_SRC-1:0]              dst_credit_i,
  output logic [N_SRC-1:0][FLIT_W-1:0]  dst_data_o,
  output logic                          drop_o
`ifdef PERIPH_ARB_STATS_EN
  ,
  output logic [N_SRC-1:0][15:0]        pkt_cnt_o
`endif
);
  localparam int GW = $clog2(N_SRC);

  logic [GW-1:0] grant, rr_ptr, pick;
  logic          any_req, tx_start, tx_busy, tx_xfer, tx_last;
  pkt_state_e    tx_state;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick    = rr_ptr;
    any_req = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!any_req && src_tx_i[(int'(rr_ptr) + i) % N_SRC]) begin
        any_req = 1'b1;
        pick    = GW'((int'(rr_ptr) + i) % N_SRC);
      end
    end
  end

  assign tx_busy  = tx_state != PKT_IDLE;
  assign tx_start = !tx_busy && release_i && any_req;
  assign tx_xfer  = noc_tx_o && noc_credit_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      if (tx_start) grant <= pick;
      if (tx_last)  rr_ptr <= GW'((int'(grant) + 1) % N_SRC);
    end
  end

  always_comb begin
    src_credit_o = '0;
    noc_tx_o     = 1'b0;
    noc_data_o   = '0;
    if (tx_busy) begin
      noc_tx_o            = src_tx_i[grant];
      noc_data_o          = src_data_i[grant];
      src_credit_o[grant] = noc_credit_i;
    end
  end

  periph_pkt_tracker #(.HAS_IDLE(1'b1)) u_tx (
    .clk(clk_i), .rst(rst_i), .start(tx_start), .xfer(tx_xfer),
    .data(src_data_i[grant]), .state(tx_state), .last_o(tx_last)
  );

  // RX: the header is steered by its own pid field, later flits by the latched copy.
  pkt_state_e       rx_state;
  logic [PID_W-1:0] pid, dst_q, dst;
  logic             rx_hdr, dst_ok, rx_xfer, rx_last, drop_q;

  assign pid     = noc_data_i[PID_LSB +: PID_W];
  assign rx_hdr  = rx_state == PKT_HDR;
  assign dst     = rx_hdr ? pid : dst_q;
  assign dst_ok  = int'(dst) < N_SRC;
  assign rx_xfer = noc_rx_i && noc_credit_o;
  assign drop_o  = drop_q;

  always_comb begin
    dst_rx_o     = '0;
    noc_credit_o = 1'b0;
    dst_data_o   = '0;
    if (!rst_i) begin
      noc_credit_o = !dst_ok;
      for (int d = 0; d < N_SRC; d++) begin
        dst_data_o[d] = noc_data_i;
        if (dst_ok && int'(dst) == d) begin
          dst_rx_o[d]  = noc_rx_i;
          noc_credit_o = dst_credit_i[d];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dst_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (rx_hdr && rx_xfer) dst_q <= pid;
      drop_q <= rx_last && !dst_ok;
    end
  end

  periph_pkt_tracker #(.HAS_IDLE(1'b0)) u_rx (
    .clk(clk_i), .rst(rst_i), .start(1'b0), .xfer(rx_xfer),
    .data(noc_data_i), .state(rx_state), .last_o(rx_last)
  );

`ifdef PERIPH_ARB_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        pkt_cnt_o <= '0;
    else if (tx_last) pkt_cnt_o[grant] <= pkt_cnt_o[grant] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_periph_port_arbiter.sv
// Randomized bench: per-source packet queues, a round-robin order model and per-destination RX scoreboards.
module tb_periph_port_arbiter;
  localparam int N = 4;

  logic clk = 1'b0, rst = 1'b1, rel_drv = 1'b0;
  logic [N-1:0] src_tx = '0, src_credit, dst_rx, dst_credit = '0;
  logic [N-1:0][31:0] src_data = '0, dst_data;
  logic noc_tx, noc_credit_in = 1'b0, noc_rx = 1'b0, noc_credit_out, drop;
  logic [31:0] noc_data_out, noc_data_in = '0;
`ifdef PERIPH_ARB_STATS_EN
  logic [N-1:0][15:0] pkt_cnt;
`endif

  always #5 clk = ~clk;

  periph_port_arbiter #(.N_SRC(N), .PID_LSB(16), .PID_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .release_i(rel_drv),
    .src_tx_i(src_tx), .src_credit_o(src_credit), .src_data_i(src_data),
    .noc_tx_o(noc_tx), .noc_credit_i(noc_credit_in), .noc_data_o(noc_data_out),
    .noc_rx_i(noc_rx), .noc_credit_o(noc_credit_out), .noc_data_i(noc_data_in),
    .dst_rx_o(dst_rx), .dst_credit_i(dst_credit), .dst_data_o(dst_data),
    .drop_o(drop)
`ifdef PERIPH_ARB_STATS_EN
    , .pkt_cnt_o(pkt_cnt)
`endif
  );

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] src_q[N][$];
  int          src_len[N][$];
  int          cur_left[N];
  logic [31:0] mdl[N][$];
  int          mdl_len[N][$];
  logic [31:0] exp_tx[$];
  logic [31:0] rx_q[$];
  logic [31:0] exp_rx[N][$];
  int exp_drops = 0, drops_seen = 0, model_rr = 0, tx_done = 0;
  bit rnd_rel = 1'b0, rel = 1'b1;

  task automatic add_tx(input int s, input int sz);
    logic [31:0] f;
    f = {4'(s), 4'hA, 24'($urandom)};
    src_q[s].push_back(f); mdl[s].push_back(f);
    src_q[s].push_back(32'(sz)); mdl[s].push_back(32'(sz));
    for (int k = 0; k < sz; k++) begin
      f = $urandom;
      src_q[s].push_back(f); mdl[s].push_back(f);
    end
    src_len[s].push_back(sz + 2); mdl_len[s].push_back(sz + 2);
  endtask

  task automatic add_rx(input int pid, input int sz);
    logic [31:0] f[$];
    logic [31:0] h;
    h = $urandom;
    h[18:16] = 3'(pid);
    f.push_back(h);
    f.push_back(32'(sz));
    for (int k = 0; k < sz; k++) f.push_back($urandom);
    foreach (f[k]) begin
      rx_q.push_back(f[k]);
      if (pid < N) exp_rx[pid].push_back(f[k]);
    end
    if (pid >= N) exp_drops++;
  endtask

  function automatic bit mdl_any();
    for (int i = 0; i < N; i++) if (mdl_len[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b1;
    return rx_q.size() != 0;
  endfunction

  // Whole-packet round robin over sources with packets pending.
  task automatic build_exp();
    int p, len;
    while (mdl_any()) begin
      p = -1;
      for (int i = 0; i < N; i++)
        if (p < 0 && mdl_len[(model_rr + i) % N].size() != 0) p = (model_rr + i) % N;
      len = mdl_len[p].pop_front();
      repeat (len) exp_tx.push_back(mdl[p].pop_front());
      model_rr = (p + 1) % N;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      src_tx[i]     = src_q[i].size() != 0 && (cur_left[i] == 0 || $urandom_range(3) != 0);
      src_data[i]   = src_q[i].size() != 0 ? src_q[i][0] : $urandom;
      dst_credit[i] = $urandom_range(3) != 0;
    end
    noc_credit_in = $urandom_range(3) != 0;
    noc_rx        = rx_q.size() != 0 && $urandom_range(3) != 0;
    noc_data_in   = rx_q.size() != 0 ? rx_q[0] : $urandom;
    rel_drv       = rnd_rel ? ($urandom_range(7) != 0) : rel;
    #1;
    chk("src_credit_1hot", 32'($countones(src_credit) <= 1), 32'd1);
    chk("src_sync", 32'($countones(src_tx & src_credit)), 32'(noc_tx && noc_credit_in));
    if (noc_tx && noc_credit_in) begin
      tx_done++;
      if (exp_tx.size() == 0) chk("tx_unexpected", 32'(noc_tx), 32'd0);
      else chk("tx_flit", noc_data_out, exp_tx.pop_front());
    end
    for (int i = 0; i < N; i++)
      if (src_tx[i] && src_credit[i]) begin
        void'(src_q[i].pop_front());
        if (cur_left[i] == 0) cur_left[i] = src_len[i].pop_front();
        cur_left[i]--;
      end
    chk("dst_1hot", 32'($countones(dst_rx) <= 1), 32'd1);
    for (int d = 0; d < N; d++)
      if (dst_rx[d] && dst_credit[d]) begin
        if (exp_rx[d].size() == 0) chk("rx_unexpected", 32'(dst_rx[d]), 32'd0);
        else chk("rx_flit", dst_data[d], exp_rx[d].pop_front());
      end
    if (noc_rx && noc_credit_out) void'(rx_q.pop_front());
    if (drop) drops_seen++;
  endtask

  task automatic run_round();
    int n = 0;
    build_exp();
    while (busy() && n < 3000) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    chk("round_timeout", 32'(n < 3000), 32'd1);
    chk("tx_left", 32'(exp_tx.size()), 32'd0);
    for (int d = 0; d < N; d++) chk("rx_left", 32'(exp_rx[d].size()), 32'd0);
    chk("drops", 32'(drops_seen), 32'(exp_drops));
  endtask

  // Reset with every input active; outputs must be forced idle immediately.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    src_tx = '1; noc_rx = 1'b1; dst_credit = '1; noc_credit_in = 1'b1; rel_drv = 1'b1;
    for (int i = 0; i < N; i++) src_data[i] = $urandom;
    noc_data_in = $urandom;
    #1;
    chk("rst_src_credit", 32'(src_credit), 32'd0);
    chk("rst_noc_tx", 32'(noc_tx), 32'd0);
    chk("rst_noc_data", noc_data_out, 32'd0);
    chk("rst_noc_credit", 32'(noc_credit_out), 32'd0);
    chk("rst_dst_rx", 32'(dst_rx), 32'd0);
    chk("rst_dst_data", 32'(|dst_data), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete(); src_len[i].delete(); mdl[i].delete(); mdl_len[i].delete();
      exp_rx[i].delete(); cur_left[i] = 0;
    end
    exp_tx.delete(); rx_q.delete();
    model_rr = 0;
    @(negedge clk);
    src_tx = '0; noc_rx = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int n, t0;
    for (int i = 0; i < N; i++) cur_left[i] = 0;
    do_reset();

    // Two requesters from reset, then S=0 and rr wrap.
    add_tx(0, 3); add_tx(2, 3);
    run_round();
    add_tx(3, 0); add_tx(1, 1);
    run_round();
    add_tx(3, 1); add_tx(0, 1);
    run_round();

    // RX concurrent with TX, then an invalid-id drain.
    add_tx(1, 2); add_rx(2, 1);
    run_round();
    add_rx(6, 4);
    run_round();

    // Release gating.
    rel = 1'b0;
    add_tx(0, 2);
    build_exp();
    repeat (4) begin
      cycle();
      chk("rel_block_tx", 32'(noc_tx), 32'd0);
      chk("rel_block_cred", 32'(src_credit), 32'd0);
    end
    rel = 1'b1;
    cycle();
    chk("rel_arb_cycle", 32'(noc_tx), 32'd0);
    cycle();
    chk("rel_grant", 32'(noc_tx), 32'd1);
    run_round();

    // Randomized rounds.
    rnd_rel = 1'b1;
    for (int r = 0; r < 25; r++) begin
      for (int s = 0; s < N; s++) begin
        int k;
        k = $urandom_range(2);
        repeat (k) add_tx(s, $urandom_range(4));
      end
      repeat ($urandom_range(3, 1)) add_rx($urandom_range(7), $urandom_range(4));
      run_round();
    end
    rnd_rel = 1'b0;

    // Reset in the middle of a payload.
    add_tx(1, 4);
    build_exp();
    t0 = tx_done;
    n = 0;
    while (tx_done - t0 < 3 && n < 200) begin
      cycle();
      n++;
    end
    chk("midrst_timeout", 32'(n < 200), 32'd1);
    do_reset();
    add_tx(1, 1); add_tx(0, 2);
    run_round();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
